// File: rtl/prog_mem_controller_pkg.sv
// Shared types for the program-memory controller and its arbiter.
package prog_mem_controller_pkg;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_READ_WAITING,
        MC_RELAYING
    } memctl_state_t;

    // Owner index width, never narrower than one bit.
    function automatic int owner_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_mem_controller_rr_grant.sv
// Combinational round-robin assignment of eligible consumers to idle channels.
module rr_grant
    import prog_mem_controller_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic [NUM_CONSUMERS-1:0]                          eligible,
    input  logic [NUM_CHANNELS-1:0]                           idle,
    input  logic [owner_bits(NUM_CONSUMERS)-1:0]              rr_ptr,
    output logic [NUM_CHANNELS*owner_bits(NUM_CONSUMERS)-1:0] grant_idx,
    output logic [NUM_CHANNELS-1:0]                           grant_valid,
    output logic [owner_bits(NUM_CONSUMERS)-1:0]              next_ptr
);

    localparam int OWNER_BITS = owner_bits(NUM_CONSUMERS);

    logic [NUM_CONSUMERS-1:0] avail;
    logic                     found;
    logic [OWNER_BITS-1:0]    cand;

    // Channels are filled in ascending order; a consumer taken by one channel
    // is removed from avail so no later channel can pick it in the same cycle.
    always_comb begin
        avail       = eligible;
        found       = 1'b0;
        cand        = '0;
        grant_idx   = '0;
        grant_valid = '0;
        next_ptr    = rr_ptr;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            found = 1'b0;
            for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
                cand = OWNER_BITS'((32'(rr_ptr) + i) % NUM_CONSUMERS);
                if (idle[c] && !found && avail[cand]) begin
                    found          = 1'b1;
                    avail[cand]    = 1'b0;
                    grant_valid[c] = 1'b1;
                    grant_idx[c*OWNER_BITS +: OWNER_BITS] = cand;
                    next_ptr       = OWNER_BITS'((32'(cand) + 1) % NUM_CONSUMERS);
                end
            end
        end
    end

endmodule

// File: rtl/prog_mem_controller.sv
// Read-only program-memory controller: round-robin fetch multiplexing onto memory channels.
module prog_mem_controller
    import prog_mem_controller_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data
);

    localparam int OWNER_BITS = owner_bits(NUM_CONSUMERS);

    memctl_state_t                           state [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][OWNER_BITS-1:0] owner;
    logic [NUM_CONSUMERS-1:0]                busy;
    logic [OWNER_BITS-1:0]                   rr_ptr;
    logic [OWNER_BITS-1:0]                   next_ptr;
    logic [NUM_CONSUMERS-1:0]                eligible;
    logic [NUM_CHANNELS-1:0]                 idle;
    logic [NUM_CHANNELS-1:0]                 grant_valid;
    logic [NUM_CHANNELS*OWNER_BITS-1:0]      grant_idx;

    assign eligible = consumer_read_valid & ~busy;

    always_comb begin
        idle = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            idle[c] = (state[c] == MC_IDLE);
        end
    end

    rr_grant #(
        .NUM_CONSUMERS(NUM_CONSUMERS),
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_rr_grant (
        .eligible   (eligible),
        .idle       (idle),
        .rr_ptr     (rr_ptr),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .next_ptr   (next_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            mem_read_valid      <= '0;
            mem_read_address    <= '0;
            busy                <= '0;
            rr_ptr              <= '0;
            owner               <= '0;
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                state[c] <= MC_IDLE;
            end
        end else begin
            rr_ptr <= next_ptr;
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    MC_IDLE: begin
                        if (grant_valid[c]) begin
                            owner[c]          <= grant_idx[c*OWNER_BITS +: OWNER_BITS];
                            busy[grant_idx[c*OWNER_BITS +: OWNER_BITS]] <= 1'b1;
                            mem_read_valid[c] <= 1'b1;
                            mem_read_address[c*ADDR_BITS +: ADDR_BITS] <=
                                consumer_read_address[grant_idx[c*OWNER_BITS +: OWNER_BITS]*ADDR_BITS +: ADDR_BITS];
                            state[c]          <= MC_READ_WAITING;
                        end
                    end
                    MC_READ_WAITING: begin
                        if (mem_read_ready[c]) begin
                            consumer_read_data[owner[c]*DATA_BITS +: DATA_BITS] <=
                                mem_read_data[c*DATA_BITS +: DATA_BITS];
                            consumer_read_ready[owner[c]] <= 1'b1;
                            mem_read_valid[c]             <= 1'b0;
                            state[c]                      <= MC_RELAYING;
                        end
                    end
                    MC_RELAYING: begin
                        if (!consumer_read_valid[owner[c]]) begin
                            consumer_read_ready[owner[c]] <= 1'b0;
                            busy[owner[c]]                <= 1'b0;
                            state[c]                      <= MC_IDLE;
                        end
                    end
                    default: state[c] <= MC_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_mem_controller.sv
// Scoreboard bench: fetcher/memory models feed expected data queues checked by a monitor.
module tb_prog_mem_controller;

    localparam int AB = 8;
    localparam int DB = 16;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // single-channel instance
    logic [NC-1:0]    c_valid;
    logic [NC*AB-1:0] c_addr;
    logic [NC-1:0]    c_ready;
    logic [NC*DB-1:0] c_data;
    logic [0:0]       m_valid;
    logic [AB-1:0]    m_addr;
    logic [0:0]       m_ready;
    logic [DB-1:0]    m_data;

    // two-channel instance
    logic [NC-1:0]    v2;
    logic [NC*AB-1:0] a2;
    logic [NC-1:0]    r2;
    logic [NC*DB-1:0] d2;
    logic [1:0]       mv2;
    logic [2*AB-1:0]  ma2;
    logic [1:0]       mr2;
    logic [2*DB-1:0]  md2;

    prog_mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_valid), .consumer_read_address(c_addr),
        .consumer_read_ready(c_ready), .consumer_read_data(c_data),
        .mem_read_valid(m_valid), .mem_read_address(m_addr),
        .mem_read_ready(m_ready), .mem_read_data(m_data)
    );

    prog_mem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(v2), .consumer_read_address(a2),
        .consumer_read_ready(r2), .consumer_read_data(d2),
        .mem_read_valid(mv2), .mem_read_address(ma2),
        .mem_read_ready(mr2), .mem_read_data(md2)
    );

    logic [DB-1:0] mem_model [256];
    logic [DB-1:0] exp_q [NC][$];
    logic [AB-1:0] grant_q [$];
    int            checks = 0;
    int            errors = 0;
    int            fixed_lat;
    bit            spurious_req;
    bit            check_grants;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Memory: answers fixed_lat cycles after seeing a request (random 0..3 when negative).
    task automatic mem_responder();
        bit active = 1'b0;
        int cnt = 0;
        int lat = 0;
        forever begin
            @(negedge clk);
            m_ready = 1'b0;
            if (reset) begin
                active = 1'b0;
            end else if (spurious_req && !m_valid[0]) begin
                m_ready      = 1'b1;
                m_data       = 16'hDEAD;
                spurious_req = 1'b0;
            end else if (m_valid[0]) begin
                if (!active) begin
                    active = 1'b1;
                    cnt    = 0;
                    lat    = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                end
                if (cnt == lat) begin
                    m_ready = 1'b1;
                    m_data  = mem_model[m_addr];
                    active  = 1'b0;
                end else begin
                    cnt++;
                end
            end
        end
    endtask

    task automatic monitor();
        logic [NC-1:0] prev_ready = '0;
        logic [NC-1:0] prev_valid = '0;
        logic [NC-1:0] seen_ready = '0;
        logic          prev_mv    = 1'b0;
        logic [DB-1:0] e;
        logic [AB-1:0] g;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ready = '0;
                prev_valid = '0;
                seen_ready = '0;
                prev_mv    = 1'b0;
            end else begin
                for (int k = 0; k < NC; k++) begin
                    if (c_ready[k] && !prev_ready[k]) begin
                        if (exp_q[k].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_ready_c%0d: got ready=1 data=%0h required ready=0", k, c_data[k*DB +: DB]);
                        end else begin
                            e = exp_q[k].pop_front();
                            check($sformatf("resp_data_c%0d", k), 64'(c_data[k*DB +: DB]), 64'(e));
                        end
                    end
                    if (c_valid[k] && !prev_valid[k]) seen_ready[k] = 1'b0;
                    if (c_ready[k]) seen_ready[k] = 1'b1;
                    if (!c_valid[k] && prev_valid[k])
                        check($sformatf("valid_drop_after_ready_c%0d", k), 64'(seen_ready[k]), 64'd1);
                end
                if (m_valid[0] && !prev_mv && check_grants) begin
                    if (grant_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_grant: got addr %0h required no grant", m_addr);
                    end else begin
                        g = grant_q.pop_front();
                        check("grant_addr", 64'(m_addr), 64'(g));
                    end
                end
                prev_ready = c_ready;
                prev_valid = c_valid;
                prev_mv    = m_valid[0];
            end
        end
    endtask

    // Standard fetcher: hold until ready, drop valid one edge later, expect ready to follow.
    task automatic fetch(input int k, input logic [AB-1:0] addr, output int cycles);
        c_addr[k*AB +: AB] = addr;
        c_valid[k]         = 1'b1;
        exp_q[k].push_back(mem_model[addr]);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!c_ready[k] && cycles < 300);
        if (!c_ready[k]) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout_c%0d: got no ready in %0d cycles required ready", k, cycles);
            c_valid[k] = 1'b0;
            return;
        end
        @(negedge clk);
        check($sformatf("ready_hold_c%0d", k), 64'(c_ready[k]), 64'd1);
        c_valid[k] = 1'b0;
        @(negedge clk);
        check($sformatf("ready_drop_c%0d", k), 64'(c_ready[k]), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_c_ready"}, 64'(c_ready), 64'd0);
        check({tag, "_c_data"},  64'(c_data),  64'd0);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_addr"},  64'(m_addr),  64'd0);
    endtask

    initial begin
        int cy;
        int n;
        c_valid = '0; c_addr = '0; m_ready = '0; m_data = '0;
        v2 = '0; a2 = '0; mr2 = '0; md2 = '0;
        reset = 1'b1; fixed_lat = -1; spurious_req = 1'b0; check_grants = 1'b0;
        for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
        mem_model[8'h05] = 16'hA1B2;

        fork
            mem_responder();
            monitor();
            begin
                #2000000;
                $display("FAIL watchdog: got timeout required completion");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");
        check("reset_rr_ptr", 64'(u_dut1.rr_ptr), 64'd0);

        // contention: all four at once, one channel
        check_grants = 1'b1;
        for (int k = 0; k < NC; k++) grant_q.push_back(8'(8'h10 + k));
        fork
            begin int c0; fetch(0, 8'h10, c0); end
            begin int c1; fetch(1, 8'h11, c1); end
            begin int c2; fetch(2, 8'h12, c2); end
            begin int c3; fetch(3, 8'h13, c3); end
        join
        check("contention_grants_left", 64'(grant_q.size()), 64'd0);
        check("contention_rr_wrap", 64'(u_dut1.rr_ptr), 64'd0);

        // fairness: 0 and 2 re-request immediately
        for (int i = 0; i < 3; i++) begin
            grant_q.push_back(8'(8'h40 + i));
            grant_q.push_back(8'(8'h60 + i));
        end
        fork
            begin int ca; for (int i = 0; i < 3; i++) fetch(0, 8'(8'h40 + i), ca); end
            begin int cb; for (int i = 0; i < 3; i++) fetch(2, 8'(8'h60 + i), cb); end
        join
        check("fairness_grants_left", 64'(grant_q.size()), 64'd0);
        check_grants = 1'b0;

        // single consumer, memory answers immediately
        fixed_lat = 0;
        fetch(0, 8'h05, cy);
        check("single_latency", 64'(cy), 64'd2);
        check("single_data_hold", 64'(c_data[0 +: DB]), 64'h0000_0000_0000_A1B2);
        check("single_addr_hold", 64'(m_addr), 64'h05);

        // spurious ready while idle, then a 10-cycle stall
        spurious_req = 1'b1;
        repeat (3) @(negedge clk);
        check("spurious_data_hold", 64'(c_data[0 +: DB]), 64'h0000_0000_0000_A1B2);
        check("spurious_no_ready", 64'(c_ready), 64'd0);
        fixed_lat = 10;
        fork
            fetch(1, 8'h77, cy);
            begin
                @(negedge clk);
                for (int i = 0; i < 10; i++) begin
                    check("stall_valid", 64'(m_valid), 64'd1);
                    check("stall_addr", 64'(m_addr), 64'h77);
                    check("stall_no_ready", 64'(c_ready), 64'd0);
                    @(negedge clk);
                end
            end
        join
        check("stall_latency", 64'(cy), 64'd12);

        // reset while waiting on memory
        fixed_lat = 1000;
        c_addr[0 +: AB] = 8'h33;
        c_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_waiting", 64'(m_valid), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset_waiting");
        c_valid = '0;
        @(negedge clk);
        reset = 1'b0;

        // reset while relaying
        fixed_lat = 0;
        c_addr[0 +: AB] = 8'h34;
        c_valid[0] = 1'b1;
        exp_q[0].push_back(mem_model[8'h34]);
        n = 0;
        do begin @(negedge clk); n++; end while (!c_ready[0] && n < 20);
        check("pre_reset_relaying", 64'(c_ready[0]), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset_relaying");
        c_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        check("post_reset_rr_ptr", 64'(u_dut1.rr_ptr), 64'd0);
        fetch(2, 8'h99, cy);
        check("post_reset_latency", 64'(cy), 64'd2);

        // randomized traffic
        fixed_lat = -1;
        fork
            begin int r0; for (int i = 0; i < 8; i++) begin repeat ($urandom_range(0, 3)) @(negedge clk); fetch(0, 8'($urandom_range(0, 255)), r0); end end
            begin int r1; for (int i = 0; i < 8; i++) begin repeat ($urandom_range(0, 3)) @(negedge clk); fetch(1, 8'($urandom_range(0, 255)), r1); end end
            begin int r2x; for (int i = 0; i < 8; i++) begin repeat ($urandom_range(0, 3)) @(negedge clk); fetch(2, 8'($urandom_range(0, 255)), r2x); end end
            begin int r3; for (int i = 0; i < 8; i++) begin repeat ($urandom_range(0, 3)) @(negedge clk); fetch(3, 8'($urandom_range(0, 255)), r3); end end
        join
        for (int k = 0; k < NC; k++)
            check($sformatf("random_pending_c%0d", k), 64'(exp_q[k].size()), 64'd0);

        // two channels: consumers 0/1 granted together, then 2/3
        a2 = {8'h33, 8'h32, 8'h31, 8'h30};
        v2 = '1;
        @(negedge clk);
        check("dual_valid_a", 64'(mv2), 64'd3);
        check("dual_addr_a", 64'(ma2), 64'h3130);
        md2 = {mem_model[8'h31], mem_model[8'h30]};
        mr2 = 2'b11;
        @(negedge clk);
        mr2 = 2'b00;
        check("dual_ready_a", 64'(r2), 64'h3);
        check("dual_data_a", 64'(d2[31:0]), 64'({mem_model[8'h31], mem_model[8'h30]}));
        check("dual_mvalid_low", 64'(mv2), 64'd0);
        v2[1:0] = 2'b00;
        repeat (2) @(negedge clk);
        check("dual_valid_b", 64'(mv2), 64'd3);
        check("dual_addr_b", 64'(ma2), 64'h3332);
        md2 = {mem_model[8'h33], mem_model[8'h32]};
        mr2 = 2'b11;
        @(negedge clk);
        mr2 = 2'b00;
        check("dual_ready_b", 64'(r2), 64'hC);
        check("dual_data_b", 64'(d2[63:32]), 64'({mem_model[8'h33], mem_model[8'h32]}));
        v2 = '0;
        repeat (2) @(negedge clk);
        check("dual_ready_drop", 64'(r2), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
